fft_frame_scheduler: RTL and testbench

//  Sequences a continuous audio sample stream into the 32-point fft core as overlapping frames.

---
 rtl/fft_frame_scheduler.sv | 179 +++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// Buffers a continuous sample stream, bursts overlapping FRAME_LEN-sample frames into the fft core
// every HOP samples, and re-times the returned bins with index, last flag and a frame counter.
module fft_frame_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 32,
    parameter int unsigned HOP        = 16,
    parameter int unsigned BUF_DEPTH  = 48,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_ready,
    input  logic                  fft_ready,
    output logic                  fft_valid_in,
    output logic [DATA_WIDTH-1:0] fft_real_in,
    output logic [DATA_WIDTH-1:0] fft_imag_in,
    input  logic                  fft_valid_out,
    input  logic [DATA_WIDTH-1:0] fft_real_out,
    input  logic [DATA_WIDTH-1:0] fft_imag_out,
    output logic                  bin_valid,
    output logic [DATA_WIDTH-1:0] bin_real,
    output logic [DATA_WIDTH-1:0] bin_imag,
    output logic [4:0]            bin_index,
    output logic                  bin_last,
    output logic [15:0]           frame_count,
    output logic                  timeout_err
);
    localparam int unsigned PTR_W   = $clog2(BUF_DEPTH);
    localparam int unsigned SUM_W   = PTR_W + 1;
    localparam int unsigned AVAIL_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CNT_W   = $clog2(FRAME_LEN);
    localparam int unsigned WD_W    = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt, rd_base, rd_base_nxt, rd_addr;
    logic [SUM_W-1:0]      rd_sum, hop_sum;
    logic [AVAIL_W-1:0]    avail, avail_nxt;
    logic [CNT_W-1:0]      feed_cnt, feed_cnt_nxt, bin_cnt, bin_cnt_nxt;
    logic [WD_W-1:0]       wd_cnt, wd_cnt_nxt;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic                  wr_fire, retire;

    logic                  fft_valid_in_nxt, bin_valid_nxt, bin_last_nxt, timeout_err_nxt;
    logic [DATA_WIDTH-1:0] fft_real_in_nxt, bin_real_nxt, bin_imag_nxt;
    logic [4:0]            bin_index_nxt;
    logic [15:0]           frame_count_nxt;

    assign sample_ready = (avail < AVAIL_W'(BUF_DEPTH));
    assign wr_fire      = sample_valid && sample_ready;
    assign fft_imag_in  = '0;

    // Circular addressing without a power-of-two depth: one conditional subtract suffices.
    assign rd_sum  = {1'b0, rd_base} + SUM_W'(feed_cnt);
    assign rd_addr = (rd_sum >= SUM_W'(BUF_DEPTH)) ? PTR_W'(rd_sum - SUM_W'(BUF_DEPTH)) : PTR_W'(rd_sum);
    assign hop_sum = {1'b0, rd_base} + SUM_W'(HOP);

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            buf_mem[wr_ptr] <= sample_data;
        end
    end

    always_comb begin
        state_nxt        = state;
        wr_ptr_nxt       = wr_ptr;
        rd_base_nxt      = rd_base;
        feed_cnt_nxt     = feed_cnt;
        bin_cnt_nxt      = bin_cnt;
        wd_cnt_nxt       = wd_cnt;
        retire           = 1'b0;
        fft_valid_in_nxt = 1'b0;
        fft_real_in_nxt  = fft_real_in;
        bin_valid_nxt    = 1'b0;
        bin_last_nxt     = 1'b0;
        bin_real_nxt     = bin_real;
        bin_imag_nxt     = bin_imag;
        bin_index_nxt    = bin_index;
        frame_count_nxt  = frame_count;
        timeout_err_nxt  = timeout_err;

        if (wr_fire) begin
            wr_ptr_nxt = (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if ((avail >= AVAIL_W'(FRAME_LEN)) && fft_ready) begin
                    state_nxt    = S_FEED;
                    feed_cnt_nxt = '0;
                end
            end
            S_FEED: begin
                fft_valid_in_nxt = 1'b1;
                fft_real_in_nxt  = buf_mem[rd_addr];
                if (feed_cnt == CNT_W'(FRAME_LEN - 1)) begin
                    retire      = 1'b1;
                    rd_base_nxt = (hop_sum >= SUM_W'(BUF_DEPTH)) ? PTR_W'(hop_sum - SUM_W'(BUF_DEPTH))
                                                                 : PTR_W'(hop_sum);
                    wd_cnt_nxt  = '0;
                    bin_cnt_nxt = '0;
                    state_nxt   = S_WAIT;
                end else begin
                    feed_cnt_nxt = feed_cnt + 1'b1;
                end
            end
            S_WAIT, S_DRAIN: begin
                // Bins are forwarded one cycle late; the watchdog restarts on every received bin.
                if (fft_valid_out) begin
                    bin_valid_nxt = 1'b1;
                    bin_real_nxt  = fft_real_out;
                    bin_imag_nxt  = fft_imag_out;
                    bin_index_nxt = 5'(bin_cnt);
                    wd_cnt_nxt    = '0;
                    if (bin_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        bin_last_nxt    = 1'b1;
                        frame_count_nxt = frame_count + 16'd1;
                        state_nxt       = S_IDLE;
                    end else begin
                        bin_cnt_nxt = bin_cnt + 1'b1;
                        state_nxt   = S_DRAIN;
                    end
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = S_IDLE;
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        avail_nxt = avail + AVAIL_W'(wr_fire) - (retire ? AVAIL_W'(HOP) : '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_base      <= '0;
            avail        <= '0;
            feed_cnt     <= '0;
            bin_cnt      <= '0;
            wd_cnt       <= '0;
            fft_valid_in <= 1'b0;
            fft_real_in  <= '0;
            bin_valid    <= 1'b0;
            bin_real     <= '0;
            bin_imag     <= '0;
            bin_index    <= '0;
            bin_last     <= 1'b0;
            frame_count  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            rd_base      <= rd_base_nxt;
            avail        <= avail_nxt;
            feed_cnt     <= feed_cnt_nxt;
            bin_cnt      <= bin_cnt_nxt;
            wd_cnt       <= wd_cnt_nxt;
            fft_valid_in <= fft_valid_in_nxt;
            fft_real_in  <= fft_real_in_nxt;
            bin_valid    <= bin_valid_nxt;
            bin_real     <= bin_real_nxt;
            bin_imag     <= bin_imag_nxt;
            bin_index    <= bin_index_nxt;
            bin_last     <= bin_last_nxt;
            frame_count  <= frame_count_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Testbench for fft_frame_scheduler: frame k must carry accepted samples k*HOP .. k*HOP+FRAME_LEN-1.
`timescale 1ns/1ps
module tb_fft_frame_scheduler;
    localparam int unsigned DW  = 16;
    localparam int unsigned FL  = 32;
    localparam int unsigned HOP = 16;
    localparam int unsigned TMO = 4096;

    typedef struct {
        logic [4:0]    idx;
        logic          last;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            c;
    } bin_rec_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_ready;
    logic          fft_ready = 1'b0;
    logic          fft_valid_in;
    logic [DW-1:0] fft_real_in, fft_imag_in;
    logic          fft_valid_out = 1'b0;
    logic [DW-1:0] fft_real_out = '0;
    logic [DW-1:0] fft_imag_out = '0;
    logic          bin_valid;
    logic [DW-1:0] bin_real, bin_imag;
    logic [4:0]    bin_index;
    logic          bin_last;
    logic [15:0]   frame_count;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int exp_frames = 0;
    int last_acc_cyc = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] fed_q[$];
    int            fed_cyc_q[$];
    bin_rec_t      bin_q[$];

    fft_frame_scheduler dut (
        .clock(clock), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .fft_ready(fft_ready), .fft_valid_in(fft_valid_in), .fft_real_in(fft_real_in),
        .fft_imag_in(fft_imag_in), .fft_valid_out(fft_valid_out), .fft_real_out(fft_real_out),
        .fft_imag_out(fft_imag_out), .bin_valid(bin_valid), .bin_real(bin_real),
        .bin_imag(bin_imag), .bin_index(bin_index), .bin_last(bin_last),
        .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Record everything the DUT presents, stamped with the edge that produced it.
    always @(negedge clock) begin
        if (fft_valid_in === 1'b1) begin
            fed_q.push_back(fft_real_in);
            fed_cyc_q.push_back(cyc);
            checks++;
            if (fft_imag_in !== '0) begin
                errors++;
                $display("FAIL imag_in: got %h need 0000", fft_imag_in);
            end
        end
        if (bin_valid === 1'b1) bin_q.push_back('{bin_index, bin_last, bin_real, bin_imag, cyc});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: +1.0 x8 / -1.0 x8 pattern, 1: value = sample index, 2: random
    task automatic push_samples(input int n, input int mode);
        int done = 0;
        int budget = 0;
        bit need = 1'b1;
        bit acc;
        logic [DW-1:0] v = '0;
        while (done < n && budget < 3000) begin
            if (need) begin
                case (mode)
                    0:       v = (((done / 8) % 2) == 0) ? 16'h4000 : 16'hC000;
                    1:       v = 16'(model_q.size());
                    default: v = 16'($urandom);
                endcase
                need = 1'b0;
            end
            sample_valid = 1'b1;
            sample_data  = v;
            acc = sample_ready;
            tick();
            if (acc) begin
                model_q.push_back(v);
                done++;
                n_acc++;
                last_acc_cyc = cyc - 1;
                need = 1'b1;
            end
            budget++;
        end
        sample_valid = 1'b0;
        checks++;
        if (done != n) begin
            errors++;
            $display("FAIL push_accept: got %0d accepted, need %0d", done, n);
        end
    endtask

    task automatic wait_feed(input int k, output int last_stamp);
        int t = 0;
        bit ok = 1'b1;
        while (fed_q.size() < (k + 1) * FL && t < 600) begin
            tick();
            t++;
        end
        last_stamp = cyc;
        checks++;
        if (fed_q.size() < (k + 1) * FL) begin
            errors++;
            $display("FAIL feed_count frame %0d: got %0d samples, need %0d", k, fed_q.size() - k * FL, FL);
            return;
        end
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (fed_q[k * FL + i] !== model_q[k * HOP + i]) begin
                errors++;
                $display("FAIL feed_data frame %0d pos %0d: got %h need %h", k, i,
                         fed_q[k * FL + i], model_q[k * HOP + i]);
            end
        end
        for (int i = 1; i < FL; i++) if (fed_cyc_q[k * FL + i] != fed_cyc_q[k * FL] + i) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL feed_contiguous frame %0d: got span %0d need %0d", k,
                     fed_cyc_q[k * FL + FL - 1] - fed_cyc_q[k * FL], FL - 1);
        end
        last_stamp = fed_cyc_q[k * FL + FL - 1];
    endtask

    task automatic drive_bins(input bit gapped);
        logic [DW-1:0] er[FL];
        logic [DW-1:0] ei[FL];
        int dc[FL];
        int start = bin_q.size();
        int j = 0;
        bit gap = 1'b0;
        bin_rec_t b;
        while (j < FL) begin
            if (gap) begin
                fft_valid_out = 1'b0;
                fft_real_out  = 16'($urandom);
                fft_imag_out  = 16'($urandom);
                gap = ($urandom_range(0, 3) == 0);
            end else begin
                er[j] = 16'($urandom);
                ei[j] = 16'($urandom);
                fft_valid_out = 1'b1;
                fft_real_out  = er[j];
                fft_imag_out  = ei[j];
                dc[j] = cyc;
                j++;
                gap = gapped;
            end
            tick();
        end
        fft_valid_out = 1'b0;
        tick();
        tick();
        exp_frames++;
        checks++;
        if (bin_q.size() - start != FL) begin
            errors++;
            $display("FAIL bin_count: got %0d bins need %0d", bin_q.size() - start, FL);
        end
        for (int i = 0; i < FL; i++) begin
            if (start + i < bin_q.size()) begin
                b = bin_q[start + i];
                checks++;
                if (b.idx !== 5'(i) || b.last !== (i == FL - 1) || b.re !== er[i] || b.im !== ei[i] ||
                    b.c != dc[i] + 1) begin
                    errors++;
                    $display("FAIL bin %0d: got idx=%0d last=%b re=%h im=%h cyc=%0d need idx=%0d last=%b re=%h im=%h cyc=%0d",
                             i, b.idx, b.last, b.re, b.im, b.c, i, (i == FL - 1), er[i], ei[i], dc[i] + 1);
                end
            end
        end
        checks++;
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL frame_count: got %0d need %0d", frame_count, exp_frames);
        end
    endtask

    task automatic run_frame(input int k, input bit gapped);
        int ls;
        wait_feed(k, ls);
        drive_bins(gapped);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (fft_valid_in !== 1'b0) begin errors++; $display("FAIL rst_valid_in: got %b need 0", fft_valid_in); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_sample_ready: got %b need 1", sample_ready); end
        if (bin_valid !== 1'b0)    begin errors++; $display("FAIL rst_bin_valid: got %b need 0", bin_valid); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count: got %0d need 0", frame_count); end
        if (timeout_err !== 1'b0)  begin errors++; $display("FAIL rst_timeout: got %b need 0", timeout_err); end
        if (bin_index !== 5'd0 || bin_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_bin_fields: got idx=%0d last=%b need 0 0", bin_index, bin_last);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_first_frame();
        int ls;
        fft_ready = 1'b1;
        push_samples(32, 0);
        wait_feed(0, ls);
        checks += 4;
        if (fed_cyc_q.size() == 0 || fed_cyc_q[0] != last_acc_cyc + 3) begin
            errors++;
            $display("FAIL launch_latency: got cycle %0d need %0d", fed_cyc_q.size() ? fed_cyc_q[0] : -1, last_acc_cyc + 3);
        end
        if (fed_q.size() < 9 || fed_q[8] !== 16'hC000) begin
            errors++;
            $display("FAIL feed_neg_one: got %h need c000", fed_q.size() > 8 ? fed_q[8] : 16'hxxxx);
        end
        if (dut.avail !== 6'd16)   begin errors++; $display("FAIL avail_after_feed: got %0d need 16", dut.avail); end
        if (dut.rd_base !== 6'd16) begin errors++; $display("FAIL rd_base_first: got %0d need 16", dut.rd_base); end
        drive_bins(1'b0);
    endtask

    task automatic test_overlap();
        push_samples(16, 1);
        run_frame(1, 1'b0);
        checks += 2;
        if (dut.rd_base !== 6'd32) begin errors++; $display("FAIL rd_base_second: got %0d need 32", dut.rd_base); end
        if (dut.avail !== 6'd16)   begin errors++; $display("FAIL avail_second: got %0d need 16", dut.avail); end
    endtask

    task automatic test_backpressure();
        int start = n_acc;
        fft_ready = 1'b0;
        fork
            push_samples(60, 2);
            begin
                int t = 0;
                while (n_acc < start + 32 && t < 200) begin tick(); t++; end
                repeat (5) tick();
                checks += 2;
                if (sample_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b need 0", sample_ready); end
                if (n_acc != start + 32) begin errors++; $display("FAIL bp_accepted: got %0d need %0d", n_acc - start, 32); end
                fft_ready = 1'b1;
                run_frame(2, 1'b0);
                run_frame(3, 1'b0);
                run_frame(4, 1'b0);
            end
        join
        checks++;
        if (n_acc != start + 60) begin errors++; $display("FAIL bp_total: got %0d need 60", n_acc - start); end
    endtask

    task automatic test_timeout();
        int ls;
        int start;
        push_samples(4, 2);
        wait_feed(5, ls);
        while (cyc < ls + TMO - 1) tick();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b need 0", timeout_err); end
        tick();
        checks += 2;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b need 1", timeout_err); end
        if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL timeout_frames: got %0d need %0d", frame_count, exp_frames);
        end
        start = bin_q.size();
        fft_valid_out = 1'b1;
        repeat (3) tick();
        fft_valid_out = 1'b0;
        repeat (2) tick();
        checks += 2;
        if (bin_q.size() != start) begin errors++; $display("FAIL idle_ignore: got %0d bins need 0", bin_q.size() - start); end
        if (fed_q.size() != 6 * FL) begin errors++; $display("FAIL idle_no_launch: got %0d fed need %0d", fed_q.size(), 6 * FL); end
    endtask

    task automatic test_gapped();
        push_samples(16, 2);
        run_frame(6, 1'b1);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b need 1", timeout_err); end
    endtask

    task automatic test_reset_mid_feed();
        int t = 0;
        int n;
        push_samples(16, 2);
        while (fed_q.size() < 7 * FL + 4 && t < 200) begin tick(); t++; end
        checks++;
        if (fed_q.size() < 7 * FL + 4) begin errors++; $display("FAIL mid_feed_start: got %0d fed need %0d", fed_q.size(), 7 * FL + 4); end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (fft_valid_in !== 1'b0) begin errors++; $display("FAIL mid_rst_valid_in: got %b need 0", fft_valid_in); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b need 1", sample_ready); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_rst_frames: got %0d need 0", frame_count); end
        if (timeout_err !== 1'b0)  begin errors++; $display("FAIL mid_rst_timeout: got %b need 0", timeout_err); end
        tick();
        reset_n = 1'b1;
        n = fed_q.size();
        repeat (5) tick();
        checks++;
        if (fed_q.size() != n) begin errors++; $display("FAIL mid_rst_discard: got %0d fed need %0d", fed_q.size(), n); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_overlap();
        test_backpressure();
        test_timeout();
        test_gapped();
        test_reset_mid_feed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
